apb_gpio_master: RTL and testbench
==================================

# apb_gpio_master

Single-outstanding APB initiator that turns simple command/response requests from a local controller into APB SETUP/ACCESS transfers. It drives the APB side of the GPIO peripheral slave (data register at 0x00, direction register at 0x01) and any other slave on the same 8-bit bus. It also bounds PREADY wait states with a programmable timeout.

## Interface
- ADDR_W, 8, PADDR / cmd_addr width
- DATA_W, 8, PWDATA / PRDATA / cmd_wdata / rsp_rdata width
- TIMEOUT, 16, maximum ACCESS cycles with PREADY=0 before abort; 0 disables the timeout
- PCLK  in  1  bus clock; all logic on rising edge
- PRESET  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target register address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads; 0 on writes and on timeout
- rsp_timeout  out  1  qualifies rsp_valid: transfer aborted
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB slave ready

## Operation
- FSM states:
  - IDLE: PSEL=0, PENABLE=0, cmd_ready=1.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- IDLE -> SETUP on acceptance. cmd_write, cmd_addr and cmd_wdata are captured into PWRITE, PADDR and PWDATA on the same edge.
- SETUP -> ACCESS unconditionally after one cycle.
- ACCESS with PREADY=1 -> IDLE:
  - rsp_valid=1 and rsp_timeout=0 next cycle.
  - On a read, rsp_rdata gets PRDATA sampled at that edge.
- ACCESS with PREADY=0: stay in ACCESS and increment the wait counter.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT -> IDLE with rsp_valid=1, rsp_timeout=1, rsp_rdata=0.
- The wait counter clears on entry to SETUP. Its width is enough to hold TIMEOUT.
- PWRITE, PADDR and PWDATA are stable from SETUP through the end of ACCESS. They hold their last values in IDLE.
- cmd_valid outside IDLE is ignored; the command is not queued.
- PRDATA is ignored except when PREADY=1 in ACCESS on a read.

## Timing
- Reset values: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_timeout = 0. cmd_ready = 1 (IDLE).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Zero-wait transfer: accept at edge N, SETUP in cycle N+1, ACCESS in N+2 (PREADY=1 sampled at end of N+2), rsp_valid in N+3 with cmd_ready=1.
- Throughput: one transfer per 3 cycles at minimum. A new command can be accepted in the same cycle that rsp_valid is high.
- Each wait state adds one cycle. A timeout response arrives TIMEOUT cycles after ACCESS entry, plus one.
- PREADY=1 on the cycle the counter hits TIMEOUT: completion wins and rsp_timeout=0.
- PRESET asserted mid-transfer: PSEL and PENABLE drop immediately (asynchronously), the FSM goes to IDLE and no rsp_valid is generated for the aborted command.

## Structure
- Shared package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS}
  - GPIO register map constants GPIO_ADDR_DATA = 8'h00 and GPIO_ADDR_DIR = 8'h01
  - default widths
- Sub-module apb_wait_timer: clear/increment counter with a terminal-count flag compared against TIMEOUT, forced inactive when TIMEOUT=0.

## Test plan
- Reset: PRESET=1 for 2 cycles -> all outputs 0 and cmd_ready=1; release -> no bus activity.
- Write direction: cmd write addr 0x01 data 0xFF, slave PREADY=1 -> PSEL rises one cycle after accept, PENABLE one cycle later with PADDR=0x01 and PWDATA=0xFF stable; rsp_valid=1 with rsp_timeout=0 exactly 3 cycles after accept.
- Read data with waits: cmd read addr 0x00, slave holds PREADY=0 for 3 cycles then PREADY=1 with PRDATA=0xA5 -> ACCESS lasts 4 cycles and rsp_rdata=0xA5; cmd_valid pulses during the transfer are ignored (cmd_ready=0).
- Timeout: TIMEOUT=4, PREADY stuck at 0 -> abort after 4 ACCESS cycles with rsp_timeout=1 and rsp_rdata=0; PSEL=0 the next cycle.
- Back-to-back: cmd_valid held high with writes 0xAA then 0x55 to 0x00 and PREADY=1 -> second SETUP starts one cycle after the first rsp_valid (3-cycle period) and PWDATA sequence is 0xAA, 0x55.
- Reset mid-ACCESS: PRESET asserted during wait states -> PSEL and PENABLE drop without a clock edge and no rsp_valid; a new command after release completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB initiator definitions: FSM states, GPIO register map and default widths.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic [7:0] GPIO_ADDR_DATA = 8'h00;
    localparam logic [7:0] GPIO_ADDR_DIR  = 8'h01;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 16;

    // Counter width able to hold the value t (at least one bit).
    function automatic int timer_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB ACCESS phase; tc flags that the next increment reaches TIMEOUT.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CW = timer_width(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign tc = 1'b0;
        end else begin : g_timeout
            // Looking one count ahead lets the abort land on the same edge the count hits TIMEOUT.
            assign tc = (cnt == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/apb_gpio_master.sv
// Single-outstanding APB initiator: command/response front end, SETUP/ACCESS sequencing, PREADY timeout.
module apb_gpio_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    apb_state_e state, state_nxt;
    logic       accept, done, abort, tc;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                // A ready slave beats the timeout on the terminal cycle.
                if (PREADY) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (tc) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus strobes decode straight from the state register, so reset drops them without a clock.
    assign cmd_ready = (state == IDLE);
    assign PSEL      = (state != IDLE);
    assign PENABLE   = (state == ACCESS);

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk (PCLK),
        .rst (PRESET),
        .clr (accept),
        .inc ((state == ACCESS) && !PREADY),
        .tc  (tc)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            if (accept) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
            end
            rsp_valid   <= done | abort;
            rsp_timeout <= abort;
            if (done)
                rsp_rdata <= PWRITE ? '0 : PRDATA;
            else if (abort)
                rsp_rdata <= '0;
        end
    end

endmodule

// File: tb/tb_apb_gpio_master.sv
// Scoreboard bench for apb_gpio_master: directed commands, a scripted APB slave, queued expected responses.
module tb_apb_gpio_master;
    import apb_pkg::*;

    localparam int TO = 4;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready;
    logic       rsp_valid, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA;
    logic [7:0] PRDATA = 8'h3C;
    logic       PREADY = 1'b0;

    apb_gpio_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit         to;
        logic [7:0] rd;
    } rsp_t;
    rsp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scripted slave: PREADY after slave_waits ACCESS cycles, never if stuck; junk PRDATA when not ready.
    int         slave_waits = 0;
    bit         slave_stuck = 1'b0;
    logic [7:0] slave_rdata = 8'h00;
    int         acc_cnt = 0;

    always @(negedge PCLK) begin
        if (PSEL === 1'b1 && PENABLE === 1'b1) begin
            PREADY = !slave_stuck && (acc_cnt >= slave_waits);
            PRDATA = PREADY ? slave_rdata : 8'h3C;
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            PREADY  = 1'b0;
            PRDATA  = 8'h3C;
        end
    end

    // Response monitor: every rsp_valid must match the oldest queued expectation.
    always @(negedge PCLK) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=rsp_valid expected=no response at %0t", $time);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_timeout", rsp_timeout, e.to);
                chk("rsp_rdata", rsp_rdata, e.rd);
            end
        end
    end

    task automatic do_cmd(input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                          input int waits, input bit stuck, input logic [7:0] rd,
                          input bit exp_to, input logic [7:0] exp_rd,
                          input bit hold, input bit pulse);
        int   lat;
        rsp_t e;
        @(negedge PCLK);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        slave_waits = waits; slave_stuck = stuck; slave_rdata = rd;
        e.to = exp_to; e.rd = exp_rd;
        exp_q.push_back(e);
        @(posedge PCLK); #1;
        if (!hold) cmd_valid = 1'b0;
        chk("setup_psel", PSEL, 1);
        chk("setup_penable", PENABLE, 0);
        chk("setup_ready", cmd_ready, 0);
        chk("setup_paddr", PADDR, addr);
        lat = 1;
        while (lat < 40) begin
            @(posedge PCLK); #1;
            lat++;
            if (rsp_valid === 1'b1) break;
            chk("access_psel", PSEL, 1);
            chk("access_penable", PENABLE, 1);
            chk("access_pwrite", PWRITE, wr);
            chk("access_paddr", PADDR, addr);
            chk("access_pwdata", PWDATA, wd);
            if (lat == 2 && pulse) begin
                cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h7E; cmd_wdata = 8'h11;
            end else if (lat == 3 && pulse) begin
                chk("busy_ready", cmd_ready, 0);
                cmd_valid = 1'b0;
            end
        end
        chk("latency", lat, stuck ? (TO + 2) : (waits + 3));
        chk("rsp_psel", PSEL, 0);
        chk("rsp_ready", cmd_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(negedge PCLK);
        PRESET = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("idle_psel", PSEL, 0);

        // Write direction register, zero waits; write returns rdata 0 despite PRDATA
        do_cmd(1'b1, GPIO_ADDR_DIR, 8'hFF, 0, 1'b0, 8'hC3, 1'b0, 8'h00, 1'b0, 1'b0);
        // Read data with 3 waits: ready lands on the terminal count cycle, completion wins
        do_cmd(1'b0, GPIO_ADDR_DATA, 8'h00, 3, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b1);
        // Read with a single wait
        do_cmd(1'b0, GPIO_ADDR_DIR, 8'h00, 1, 1'b0, 8'h96, 1'b0, 8'h96, 1'b0, 1'b0);
        // Timeout: PREADY stuck low
        do_cmd(1'b0, GPIO_ADDR_DIR, 8'h00, 0, 1'b1, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b0);
        // Back-to-back writes with cmd_valid held across the response cycle
        do_cmd(1'b1, GPIO_ADDR_DATA, 8'hAA, 0, 1'b0, 8'hC3, 1'b0, 8'h00, 1'b1, 1'b0);
        do_cmd(1'b1, GPIO_ADDR_DATA, 8'h55, 0, 1'b0, 8'hC3, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset during ACCESS wait states: strobes drop without an edge, no response
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = GPIO_ADDR_DATA; slave_stuck = 1'b1;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        chk("pre_rst_penable", PENABLE, 1);
        #2;
        PRESET = 1'b1;
        #1;
        chk("async_psel", PSEL, 0);
        chk("async_penable", PENABLE, 0);
        chk("async_ready", cmd_ready, 1);
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_no_rsp", rsp_valid, 0);
        @(negedge PCLK);
        PRESET = 1'b0;
        slave_stuck = 1'b0;
        do_cmd(1'b0, GPIO_ADDR_DIR, 8'h00, 0, 1'b0, 8'h5A, 1'b0, 8'h5A, 1'b0, 1'b0);

        repeat (4) @(posedge PCLK);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
